sync_fifo_lvl: RTL and testbench

- Single-clock FIFO for same-domain buffering; the single-clock successor to the team's dual-clock FIFO.
- Adds an exact fill-level output and run-time almost-full/almost-empty gaps in place of a fixed parameter.
- Adds sticky overflow/underflow error flags, a synchronous flush, and a registered-read mode with a read-valid strobe.
- Sits between producer and consumer logic inside one clock domain.

---
 rtl/sync_fifo_lvl.sv | 113 +++++++++++
 tb/tb_sync_fifo_lvl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO with exact fill level, run-time almost-full/empty gaps, sticky errors and flush.
// Latency: registered read returns data 1 cycle after rinc; define SYNC_FIFO_FWFT_EN for first-word-fall-through.
// Backpressure: writes while full and reads while empty are dropped and raise sticky overflow/underflow.
module sync_fifo_lvl #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                winc,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   af_gap,
    input  logic [ADDRSIZE:0]   ae_gap,
    output logic [DATASIZE-1:0] rdata,
    output logic                rvalid,
    output logic                wfull,
    output logic                rempty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [ADDRSIZE:0]   level,
    output logic                overflow,
    output logic                underflow
);

    localparam int                DEPTH   = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] DEPTH_W = (ADDRSIZE+1)'(DEPTH);
    localparam logic [ADDRSIZE:0] ONE     = (ADDRSIZE+1)'(1);

    logic [DATASIZE-1:0] mem [DEPTH];
    logic [ADDRSIZE:0]   wbin_q, wbin_d, rbin_q, rbin_d, count_q, count_d;
    logic                ovf_q, ovf_d, udf_q, udf_d;
    logic                wr_acc, rd_acc;

    assign wfull        = (count_q == DEPTH_W);
    assign rempty       = (count_q == '0);
    assign level        = count_q;
    assign almost_full  = ((DEPTH_W - count_q) <= af_gap);
    assign almost_empty = (count_q <= ae_gap);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // Accept decisions use this cycle's registered count, so a full FIFO
    // never passes a simultaneous write through to the read side.
    assign wr_acc = winc & ~wfull & ~flush;
    assign rd_acc = rinc & ~rempty & ~flush;

    always_comb begin
        wbin_d  = wbin_q;
        rbin_d  = rbin_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (flush) begin
            wbin_d  = '0;
            rbin_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (wr_acc) wbin_d = wbin_q + ONE;
            if (rd_acc) rbin_d = rbin_q + ONE;
            if (wr_acc && !rd_acc) count_d = count_q + ONE;
            if (rd_acc && !wr_acc) count_d = count_q - ONE;
            if (winc && wfull)  ovf_d = 1'b1;
            if (rinc && rempty) udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_q  <= '0;
            rbin_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            rbin_q  <= rbin_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wbin_q[ADDRSIZE-1:0]] <= wdata;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rdata  = mem[rbin_q[ADDRSIZE-1:0]];
    assign rvalid = ~rempty;
`else
    logic [DATASIZE-1:0] rdata_q;
    logic                rvalid_q;

    // rdata holds the last popped word; flush leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_acc;
            if (rd_acc) rdata_q <= mem[rbin_q[ADDRSIZE-1:0]];
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Directed bench for sync_fifo_lvl: queue-based reference model checked every cycle plus literal spot checks.
module tb_sync_fifo_lvl;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          winc = 1'b0;
    logic          rinc = 1'b0;
    logic [AW:0]   af_gap = 5'd3;
    logic [AW:0]   ae_gap = 5'd2;
    logic [DW-1:0] rdata;
    logic          rvalid, wfull, rempty, almost_full, almost_empty, overflow, underflow;
    logic [AW:0]   level;

    int total = 0;
    int bad   = 0;

    sync_fifo_lvl #(.DATASIZE(DW), .ADDRSIZE(AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wdata(wdata), .winc(winc), .rinc(rinc),
        .af_gap(af_gap), .ae_gap(ae_gap), .rdata(rdata), .rvalid(rvalid), .wfull(wfull),
        .rempty(rempty), .almost_full(almost_full), .almost_empty(almost_empty),
        .level(level), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, outputs derived from its size.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rdata = '0;
    logic          m_rvalid = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_rdata  = '0;
            m_rvalid = 1'b0;
            m_ovf    = 1'b0;
            m_udf    = 1'b0;
        end else if (flush) begin
            q.delete();
            m_rvalid = 1'b0;
            m_ovf    = 1'b0;
            m_udf    = 1'b0;
        end else begin
            automatic bit full  = (q.size() == DEPTH);
            automatic bit empty = (q.size() == 0);
            if (winc && full)  m_ovf = 1'b1;
            if (rinc && empty) m_udf = 1'b1;
            m_rvalid = rinc && !empty;
            if (rinc && !empty) m_rdata = q.pop_front();
            if (winc && !full)  q.push_back(wdata);
        end
    end

    always @(negedge clk) begin
        automatic int n = q.size();
        check("level", 32'(level), 32'(n));
        check("rempty", 32'(rempty), 32'(n == 0));
        check("wfull", 32'(wfull), 32'(n == DEPTH));
        check("almost_full", 32'(almost_full), 32'((DEPTH - n) <= int'(af_gap)));
        check("almost_empty", 32'(almost_empty), 32'(n <= int'(ae_gap)));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
        check("rvalid", 32'(rvalid), 32'(n != 0));
        if (n != 0) check("rdata_head", 32'(rdata), 32'(q[0]));
`else
        check("rvalid", 32'(rvalid), 32'(m_rvalid));
        check("rdata", 32'(rdata), 32'(m_rdata));
`endif
    end

    // Inputs change 1 time unit after each rising edge and stay stable through the next one.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
        winc  = w;
        rinc  = r;
        wdata = d;
        @(posedge clk);
        #1;
        winc = 1'b0;
        rinc = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_level", 32'(level), 32'd0);
        check("rst_rempty", 32'(rempty), 32'd1);
        check("rst_ae", 32'(almost_empty), 32'd1);
        check("rst_af", 32'(almost_full), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, DW'(i));
            check("fill_level", 32'(level), 32'(i + 1));
            check("fill_af", 32'(almost_full), 32'((i + 1) >= 13));
        end
        check("full_wfull", 32'(wfull), 32'd1);
        check("full_ovf0", 32'(overflow), 32'd0);

        step(1'b1, 1'b0, 8'hAA);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_level", 32'(level), 32'd16);

        step(1'b1, 1'b1, 8'hBB);
        check("both_level", 32'(level), 32'd15);
        check("both_ovf", 32'(overflow), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
        check("both_rvalid", 32'(rvalid), 32'd1);
        check("both_rdata", 32'(rdata), 32'h00);
`endif

        for (int i = 1; i < 16; i++) begin
            step(1'b0, 1'b1, '0);
            check("drain_level", 32'(level), 32'(15 - i));
`ifndef SYNC_FIFO_FWFT_EN
            check("drain_rdata", 32'(rdata), 32'(i));
`endif
        end
        check("drain_empty", 32'(rempty), 32'd1);
        step(1'b0, 1'b1, '0);
        check("udf_set", 32'(underflow), 32'd1);

        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, DW'(8'h30 + i));
            step(1'b0, 1'b1, '0);
            check("wrap_level", 32'(level <= 2), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
            check("wrap_rdata", 32'(rdata), 32'(8'h30 + i));
`endif
        end

        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, DW'(8'h70 + i));
        check("pre_flush_level", 32'(level), 32'd7);
        check("pre_flush_errs", 32'({overflow, underflow}), 32'b11);
        flush = 1'b1;
        step(1'b1, 1'b1, 8'hEE);
        flush = 1'b0;
        check("flush_level", 32'(level), 32'd0);
        check("flush_rempty", 32'(rempty), 32'd1);
        check("flush_errs", 32'({overflow, underflow}), 32'b00);
        step(1'b1, 1'b0, 8'h5C);
`ifdef SYNC_FIFO_FWFT_EN
        check("fwft_5c", 32'(rdata), 32'h5C);
`endif
        step(1'b0, 1'b1, '0);
`ifndef SYNC_FIFO_FWFT_EN
        check("post_flush_rdata", 32'(rdata), 32'h5C);
        check("post_flush_rvalid", 32'(rvalid), 32'd1);
`endif

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(i));
        rst_n = 1'b0;
        #1;
        check("async_rst_level", 32'(level), 32'd0);
        check("async_rst_rdata", 32'(rdata), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
